// File: rtl/hoene_led_pkg.sv
// Shared types and constants for the LED update scheduler: FSM states, default PWM
// width and the placement of each colour field inside the packed data word.
package hoene_led_pkg;

   typedef enum logic [1:0] {
      StBlank,
      StArmed,
      StRun,
      StRunPending
   } led_state_e;

   localparam int unsigned PwmBitsDefault = 10;

   // Field index within data_in: {blue, green, red}, red in the LSBs.
   localparam int unsigned RedField   = 0;
   localparam int unsigned GreenField = 1;
   localparam int unsigned BlueField  = 2;

   function automatic int unsigned colour_lsb(input int unsigned field,
                                              input int unsigned bits);
      return field * bits;
   endfunction

endpackage

// File: rtl/hoene_period_watchdog.sv
// Saturating period counter: clear has priority over increment, expired is high
// while the count sits at the limit.
module hoene_period_watchdog #(
   parameter int unsigned TIMEOUT_PERIODS = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int unsigned CntW = $clog2(TIMEOUT_PERIODS + 1);
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_PERIODS);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != Limit)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == Limit);

endmodule

// File: rtl/hoene_led_update_scheduler.sv
// PWM timebase plus shadow/active colour registers; frames commit only at the
// period wrap so a period never shows a torn colour, and a watchdog blanks on silence.
module hoene_led_update_scheduler
   import hoene_led_pkg::*;
#(
   parameter int unsigned PWM_BITS        = PwmBitsDefault,
   parameter int unsigned TIMEOUT_PERIODS = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  store_i,
   input  logic [3*PWM_BITS-1:0] data_in_i,
   output logic [PWM_BITS-1:0]   pwm_count_o,
   output logic                  period_start_o,
   output logic [PWM_BITS-1:0]   red_o,
   output logic [PWM_BITS-1:0]   green_o,
   output logic [PWM_BITS-1:0]   blue_o,
   output logic                  blanked_o,
   output logic                  overrun_o
);

   localparam int unsigned RedLsb   = colour_lsb(RedField, PWM_BITS);
   localparam int unsigned GreenLsb = colour_lsb(GreenField, PWM_BITS);
   localparam int unsigned BlueLsb  = colour_lsb(BlueField, PWM_BITS);

   led_state_e state_q, state_d;

   logic [PWM_BITS-1:0]   cnt_q;
   logic [3*PWM_BITS-1:0] shadow_q;
   logic [PWM_BITS-1:0]   red_q, green_q, blue_q;
   logic                  blanked_q, overrun_q;

   logic wrap, wd_expired;
   logic commit, blank_now, wd_clear, wd_inc, overrun_d;

   assign wrap = &cnt_q;

   hoene_period_watchdog #(
      .TIMEOUT_PERIODS(TIMEOUT_PERIODS)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (wd_clear),
      .inc_i    (wd_inc),
      .expired_o(wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StBlank;
      end else begin
         state_q <= state_d;
      end
   end

   // A store in the wrap cycle always wins over watchdog expiry.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBlank:      if (store_i) state_d = StArmed;
         StArmed:      if (wrap) state_d = store_i ? StRunPending : StRun;
         StRun: begin
            if (store_i) begin
               state_d = StRunPending;
            end else if (wrap && wd_expired) begin
               state_d = StBlank;
            end
         end
         StRunPending: if (wrap && !store_i) state_d = StRun;
         default:      state_d = StBlank;
      endcase
   end

   always_comb begin
      commit    = wrap && ((state_q == StArmed) || (state_q == StRunPending));
      blank_now = wrap && (state_q == StRun) && wd_expired && !store_i;
      wd_clear  = store_i || (wrap && (state_q == StArmed));
      wd_inc    = wrap && ((state_q == StRun) || (state_q == StRunPending));
      overrun_d = store_i && !wrap && ((state_q == StArmed) || (state_q == StRunPending));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         shadow_q  <= '0;
         red_q     <= '0;
         green_q   <= '0;
         blue_q    <= '0;
         blanked_q <= 1'b1;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_q + PWM_BITS'(1);
         overrun_q <= overrun_d;
         if (store_i) begin
            shadow_q <= data_in_i;
         end
         // Commit reads the pre-edge shadow, so a same-cycle store waits one period.
         if (commit) begin
            red_q     <= shadow_q[RedLsb +: PWM_BITS];
            green_q   <= shadow_q[GreenLsb +: PWM_BITS];
            blue_q    <= shadow_q[BlueLsb +: PWM_BITS];
            blanked_q <= 1'b0;
         end else if (blank_now) begin
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            blanked_q <= 1'b1;
         end
      end
   end

   assign pwm_count_o    = cnt_q;
   assign period_start_o = (cnt_q == '0);
   assign red_o          = red_q;
   assign green_o        = green_q;
   assign blue_o         = blue_q;
   assign blanked_o      = blanked_q;
   assign overrun_o      = overrun_q;

endmodule
